ot_receiver: RTL and testbench
==============================

Name: ot_receiver

Overview:
Receiver end of the 1-out-of-2 RSA oblivious-transfer byte protocol; pairs with the OT sender over the 8-bit valid/ready byte streams.
- Accepts the sender's public key (N, e) and randoms x0, x1.
- Blinds its choice as v = (x_b + k^e) mod N and returns v.
- Accepts the packed pair (m0', m1') and recovers m_b = (m'_b − k) mod N.
- Sits between the UART byte link and the host-side result logic.

Parameters:
W, 32, operand width in bits; all protocol words are W bits sent as W/8 bytes (only 32 supported).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
choice  in  1  selection bit b; sampled when the first byte of a transaction is accepted
k_in  in  32  blinding secret k; sampled with choice
rx_valid  in  1  incoming byte valid
rx_ready  out  1  block can accept a byte
rx_data  in  8  incoming byte
tx_valid  out  1  outgoing byte valid
tx_ready  in  1  link accepts a byte
tx_data  out  8  outgoing byte
result  out  32  recovered message m_b; held until the next transaction completes
result_valid  out  1  one-cycle pulse when result updates
err  out  1  set when the transaction's N < 2; cleared at the start of the next transaction

Behaviour:
- Reset values: rx_ready=0, tx_valid=0, tx_data=0, result=0, result_valid=0, err=0. State goes to RECV_KEY; byte index = 0.
- Reset mid-operation aborts the transaction. Partial words are discarded, the sub-module is restarted, and rx_ready=1 on the first cycle after reset deasserts.
- Transfer rules:
  - A byte moves on rx_valid && rx_ready, or on tx_valid && tx_ready.
  - Once tx_valid is asserted, tx_valid and tx_data hold stable until accepted.
  - A new tx byte may be presented on the cycle after acceptance.
  - rx bytes offered while rx_ready=0 are not consumed.
- Byte order: little-endian, byte 0 = bits[7:0].
- States:
  - RECV_KEY: rx_ready=1. Accepts 16 bytes in order N, e, x0, x1. On byte 0, latch choice→b and k_in→k. After byte 15, rx_ready=0 and go to PREP.
  - PREP (1 cycle):
    - kr = k mod N; xs = (b ? x1 : x0) mod N.
    - If N<2: err=1, v=0, go to SEND_V.
    - Otherwise pulse exp start and go to EXP.
  - EXP: wait for exp done. Then v = xs + ke; if v ≥ N, v −= N (33-bit sum). Go to SEND_V.
  - SEND_V: transmit v as 4 bytes, then go to RECV_PACK.
  - RECV_PACK: rx_ready=1. Accepts 8 bytes, m0' then m1'. After byte 7, rx_ready=0 and go to FINISH.
  - FINISH (1 cycle):
    - mr = m'_b mod N; result = (mr ≥ kr) ? mr−kr : mr+N−kr.
    - If err: result = 0.
    - Pulse result_valid; go to RECV_KEY with index 0.
- Exponent: ke = kr^e mod N, square-and-multiply over e MSB→LSB. e=0 gives ke=1; kr=0 with e≥1 gives 0.
- Modular products: full 64-bit product reduced mod N.
- Exp latency ≤ 2·W+4 cycles from start; exact count is not checked.
- Choice/k changes outside the sample point have no effect.

Decomposition:
- Package ot_pkg:
  - W;
  - byte counts KEY_BYTES=16, V_BYTES=4, PACK_BYTES=8;
  - state enum (RECV_KEY, PREP, EXP, SEND_V, RECV_PACK, FINISH).
- Sub-module ot_mod_exp:
  - inputs clk, reset, start, base, exp, mod;
  - outputs result, done (1-cycle pulse);
  - sequential square-and-multiply, one bit per 2 cycles.
- The top keeps the FSM, byte packing and add/sub mod N.

Test Plan:
- Basic, choice=0:
  - Stimulus: k=2; N=33, e=3, x0=10, x1=4. Sender model uses d=7, m0=20, m1=5.
  - Required: v bytes 18,0,0,0. Model returns m0'=22. result=20, one result_valid pulse, err=0.
- Choice=1 with add wrap:
  - Stimulus: N=33, e=3, k=2, x1=30.
  - Required: v=5 (38−33). With m1'=1: result=(1−2) mod 33 = 32.
- Full-size:
  - Stimulus: N=128255609, e=17, d=75431153, m0=12345, m1=67890; k=5, both choices.
  - Required: result=12345 for b=0 and 67890 for b=1.
- Backpressure:
  - Stimulus: tx_ready low for 10 cycles during SEND_V, rx_valid toggled randomly.
  - Required: tx_data/tx_valid stable; all bytes correct; no byte dropped or duplicated.
- Degenerate key:
  - Stimulus: N=1.
  - Required: v=0 sent, err=1, result=0 after 8 pack bytes. Next transaction with a valid key clears err.
- Reset mid-EXP, then a full valid transaction:
  - Required: rx_ready=1 right after reset; the next transaction produces the correct result.

Source files
------------

// File: rtl/ot_pkg.sv
// rtl/ot_pkg.sv - shared widths, byte counts, FSM states and modular reduction for the OT receiver
package ot_pkg;

  localparam int W          = 32;
  localparam int KEY_BYTES  = 16;
  localparam int V_BYTES    = 4;
  localparam int PACK_BYTES = 8;

  typedef enum logic [2:0] {
    RECV_KEY  = 3'd0,
    PREP      = 3'd1,
    EXP       = 3'd2,
    SEND_V    = 3'd3,
    RECV_PACK = 3'd4,
    FINISH    = 3'd5
  } state_e;

  // Degenerate moduli reduce to 0 so a zero modulus never reaches the divider.
  function automatic logic [W-1:0] mod_reduce(input logic [2*W-1:0] a, input logic [W-1:0] n);
    if (n < W'(2)) return '0;
    return W'(a % {{W{1'b0}}, n});
  endfunction

endpackage

// File: rtl/ot_mod_exp.sv
// rtl/ot_mod_exp.sv - sequential MSB-first square-and-multiply, one exponent bit per two cycles
module ot_mod_exp
  import ot_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exp,
  input  logic [W-1:0] mod,
  output logic [W-1:0] result,
  output logic         done
);

  logic           busy_q, busy_d, phase_q, phase_d, done_q, done_d;
  logic [4:0]     bit_q, bit_d;
  logic [W-1:0]   acc_q, acc_d, base_q, base_d, exp_q, exp_d, mod_q, mod_d;
  logic [W-1:0]   mul_b, prod_red;
  logic [2*W-1:0] prod;

  // Phase 0 squares the accumulator, phase 1 conditionally multiplies by the base.
  assign mul_b    = phase_q ? base_q : acc_q;
  assign prod     = {{W{1'b0}}, acc_q} * {{W{1'b0}}, mul_b};
  assign prod_red = mod_reduce(prod, mod_q);

  always_comb begin
    busy_d  = busy_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    acc_d   = acc_q;
    base_d  = base_q;
    exp_d   = exp_q;
    mod_d   = mod_q;
    done_d  = 1'b0;
    if (start) begin
      busy_d  = 1'b1;
      phase_d = 1'b0;
      bit_d   = 5'd31;
      acc_d   = W'(1);
      base_d  = base;
      exp_d   = exp;
      mod_d   = mod;
    end else if (busy_q) begin
      if (!phase_q) begin
        acc_d   = prod_red;
        phase_d = 1'b1;
      end else begin
        if (exp_q[bit_q]) acc_d = prod_red;
        phase_d = 1'b0;
        if (bit_q == 5'd0) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          bit_d = bit_q - 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= 1'b0;
      phase_q <= 1'b0;
      done_q  <= 1'b0;
      bit_q   <= '0;
      acc_q   <= '0;
      base_q  <= '0;
      exp_q   <= '0;
      mod_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      phase_q <= phase_d;
      done_q  <= done_d;
      bit_q   <= bit_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      mod_q   <= mod_d;
    end
  end

  assign result = acc_q;
  assign done   = done_q;

endmodule

// File: rtl/ot_receiver.sv
// rtl/ot_receiver.sv - RSA 1-of-2 oblivious-transfer receiver over 8-bit valid/ready byte streams
module ot_receiver
  import ot_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         choice,
  input  logic [31:0]  k_in,
  input  logic         rx_valid,
  output logic         rx_ready,
  input  logic [7:0]   rx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [7:0]   tx_data,
  output logic [31:0]  result,
  output logic         result_valid,
  output logic         err
);

  state_e                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [KEY_BYTES*8-1:0]  key_q, key_d;
  logic [PACK_BYTES*8-1:0] pack_q, pack_d;
  logic                    b_q, b_d, err_q, err_d, rv_q, rv_d, txv_q, txv_d;
  logic [W-1:0]            k_q, k_d, kr_q, kr_d, xs_q, xs_d, v_q, v_d, res_q, res_d;
  logic [7:0]              txd_q, txd_d;
  logic [W-1:0]            n_w, e_w, x0_w, x1_w, kr_w, ke_w, mr_w;
  logic [W:0]              sum_w;
  logic                    rx_fire, exp_start, exp_done;

  // Key words arrive little-endian into a shift register: N lands lowest, x1 highest.
  assign n_w  = key_q[W-1:0];
  assign e_w  = key_q[2*W-1:W];
  assign x0_w = key_q[3*W-1:2*W];
  assign x1_w = key_q[4*W-1:3*W];

  assign rx_ready  = !reset && (state_q == RECV_KEY || state_q == RECV_PACK);
  assign rx_fire   = rx_valid && rx_ready;
  assign kr_w      = mod_reduce({{W{1'b0}}, k_q}, n_w);
  assign exp_start = (state_q == PREP) && (n_w >= W'(2));
  assign sum_w     = {1'b0, xs_q} + {1'b0, ke_w};
  assign mr_w      = mod_reduce({{W{1'b0}}, b_q ? pack_q[2*W-1:W] : pack_q[W-1:0]}, n_w);

  ot_mod_exp u_exp (
    .clk    (clk),
    .reset  (reset),
    .start  (exp_start),
    .base   (kr_w),
    .exp    (e_w),
    .mod    (n_w),
    .result (ke_w),
    .done   (exp_done)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    key_d   = key_q;
    pack_d  = pack_q;
    b_d     = b_q;
    k_d     = k_q;
    kr_d    = kr_q;
    xs_d    = xs_q;
    v_d     = v_q;
    err_d   = err_q;
    res_d   = res_q;
    txv_d   = txv_q;
    txd_d   = txd_q;
    rv_d    = 1'b0;
    case (state_q)
      RECV_KEY: if (rx_fire) begin
        key_d = {rx_data, key_q[KEY_BYTES*8-1:8]};
        if (idx_q == 4'd0) begin
          b_d   = choice;
          k_d   = k_in;
          err_d = 1'b0;
        end
        if (idx_q == 4'(KEY_BYTES - 1)) begin
          idx_d   = '0;
          state_d = PREP;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      PREP: begin
        kr_d = kr_w;
        xs_d = mod_reduce({{W{1'b0}}, b_q ? x1_w : x0_w}, n_w);
        if (n_w < W'(2)) begin
          err_d   = 1'b1;
          v_d     = '0;
          state_d = SEND_V;
        end else begin
          state_d = EXP;
        end
      end
      EXP: if (exp_done) begin
        v_d     = (sum_w >= {1'b0, n_w}) ? W'(sum_w - {1'b0, n_w}) : sum_w[W-1:0];
        state_d = SEND_V;
      end
      // Each byte is loaded one cycle, then held until the link takes it.
      SEND_V: begin
        if (!txv_q) begin
          txv_d = 1'b1;
          txd_d = v_q[{idx_q[1:0], 3'b000} +: 8];
        end else if (tx_ready) begin
          txv_d = 1'b0;
          if (idx_q == 4'(V_BYTES - 1)) begin
            idx_d   = '0;
            state_d = RECV_PACK;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      RECV_PACK: if (rx_fire) begin
        pack_d = {rx_data, pack_q[PACK_BYTES*8-1:8]};
        if (idx_q == 4'(PACK_BYTES - 1)) begin
          idx_d   = '0;
          state_d = FINISH;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      FINISH: begin
        res_d   = err_q ? '0 : ((mr_w >= kr_q) ? mr_w - kr_q : mr_w + n_w - kr_q);
        rv_d    = 1'b1;
        idx_d   = '0;
        state_d = RECV_KEY;
      end
      default: state_d = RECV_KEY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RECV_KEY;
      idx_q   <= '0;
      key_q   <= '0;
      pack_q  <= '0;
      b_q     <= 1'b0;
      k_q     <= '0;
      kr_q    <= '0;
      xs_q    <= '0;
      v_q     <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      txv_q   <= 1'b0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      pack_q  <= pack_d;
      b_q     <= b_d;
      k_q     <= k_d;
      kr_q    <= kr_d;
      xs_q    <= xs_d;
      v_q     <= v_d;
      err_q   <= err_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      txv_q   <= txv_d;
      txd_q   <= txd_d;
    end
  end

  assign tx_valid     = txv_q;
  assign tx_data      = txd_q;
  assign result       = res_q;
  assign result_valid = rv_q;
  assign err          = err_q;

endmodule

// File: tb/tb_ot_receiver.sv
// tb/tb_ot_receiver.sv - self-checking bench for ot_receiver with an arithmetic reference model
module tb_ot_receiver;

  logic        clk, reset, choice, rx_valid, rx_ready, tx_valid, tx_ready, result_valid, err;
  logic [31:0] k_in, result;
  logic [7:0]  rx_data, tx_data;

  int checks   = 0;
  int failures = 0;
  bit rnd_rx   = 0;
  bit stall_tx = 0;

  ot_receiver dut (
    .clk          (clk),
    .reset        (reset),
    .choice       (choice),
    .k_in         (k_in),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .result       (result),
    .result_valid (result_valid),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // LSB-first binary exponentiation on 64-bit integers.
  function automatic longint unsigned mexp(input longint unsigned base, input longint unsigned e,
                                           input longint unsigned n);
    longint unsigned r = 1 % n;
    longint unsigned b = base % n;
    while (e != 0) begin
      if (e[0]) r = (r * b) % n;
      b = (b * b) % n;
      e = e >> 1;
    end
    return r;
  endfunction

  task automatic send_byte(input string tag, input logic [7:0] d);
    bit done = 0;
    int guard = 0;
    while (!done && guard < 200) begin
      rx_data  = d;
      rx_valid = rnd_rx ? 1'($urandom_range(0, 1)) : 1'b1;
      done     = rx_valid && rx_ready;
      step();
      guard++;
    end
    rx_valid = 1'b0;
    check({tag, "_rx_accept"}, 64'(done), 1);
  endtask

  task automatic send_key(input string tag, input logic [31:0] n, e, x0, x1, input bit b,
                          input logic [31:0] k);
    logic [31:0] w [4];
    w[0] = n; w[1] = e; w[2] = x0; w[3] = x1;
    choice = b;
    k_in   = k;
    for (int i = 0; i < 16; i++) begin
      send_byte(tag, w[i/4][8*(i%4) +: 8]);
      if (i == 0) begin
        choice = 1'($urandom);
        k_in   = $urandom;
      end
    end
  endtask

  task automatic recv_v(input string tag, output logic [31:0] v);
    int got = 0;
    int guard = 0;
    int stall_left = 10;
    bit held = 0;
    logic [7:0] held_data = 0;
    v = 0;
    while (got < 4 && guard < 1000) begin
      if (held) begin
        check({tag, "_tx_hold_valid"}, 64'(tx_valid), 1);
        check({tag, "_tx_hold_data"}, 64'(tx_data), 64'(held_data));
      end
      if (stall_tx && tx_valid && stall_left > 0) begin
        tx_ready = 1'b0;
        stall_left--;
      end else begin
        tx_ready = stall_tx ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      held      = tx_valid && !tx_ready;
      held_data = tx_data;
      if (tx_valid && tx_ready) begin
        v[8*got +: 8] = tx_data;
        got++;
      end
      step();
      guard++;
    end
    tx_ready = 1'b0;
    check({tag, "_v_bytes"}, 64'(got), 4);
    check({tag, "_no_extra_tx"}, 64'(tx_valid), 0);
  endtask

  task automatic txn(input string tag, input logic [31:0] n, e, x0, x1, input bit b,
                     input logic [31:0] k, input bit sender, input logic [31:0] d, m0, m1,
                     mp0_in, mp1_in, output logic [31:0] v_got, output logic [31:0] res_got);
    longint unsigned nn, kr, xb, mpb;
    logic [31:0] mp0, mp1, exp_v, exp_res;
    int guard = 0;
    nn = 64'(n);
    kr = (nn < 2) ? 0 : 64'(k) % nn;
    xb = (nn < 2) ? 0 : 64'(b ? x1 : x0) % nn;
    exp_v = (nn < 2) ? 32'd0 : 32'((xb + mexp(kr, 64'(e), nn)) % nn);

    send_key(tag, n, e, x0, x1, b, k);
    // Bytes offered while the receiver is busy must not be consumed.
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    recv_v(tag, v_got);
    check({tag, "_v"}, 64'(v_got), 64'(exp_v));

    if (sender && nn >= 2) begin
      mp0 = 32'((64'(m0) + mexp((64'(v_got) % nn + nn - 64'(x0) % nn) % nn, 64'(d), nn)) % nn);
      mp1 = 32'((64'(m1) + mexp((64'(v_got) % nn + nn - 64'(x1) % nn) % nn, 64'(d), nn)) % nn);
    end else begin
      mp0 = mp0_in;
      mp1 = mp1_in;
    end
    mpb     = 64'(b ? mp1 : mp0);
    exp_res = (nn < 2) ? 32'd0 : 32'(((mpb % nn) + nn - kr) % nn);

    for (int i = 0; i < 4; i++) send_byte(tag, mp0[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(tag, mp1[8*i +: 8]);

    while (!result_valid && guard < 20) begin
      step();
      guard++;
    end
    check({tag, "_rv_pulse"}, 64'(result_valid), 1);
    res_got = result;
    check({tag, "_result"}, 64'(res_got), 64'(exp_res));
    check({tag, "_err"}, 64'(err), 64'(nn < 2));
    if (sender && nn >= 2) check({tag, "_message"}, 64'(res_got), 64'(b ? m1 : m0));
    step();
    check({tag, "_rv_single"}, 64'(result_valid), 0);
    check({tag, "_result_hold"}, 64'(result), 64'(exp_res));
  endtask

  initial begin
    logic [31:0] v, r, rn, re, rk;
    int sel;
    reset    = 1'b1;
    choice   = 1'b0;
    k_in     = '0;
    rx_valid = 1'b0;
    rx_data  = '0;
    tx_ready = 1'b0;
    repeat (3) step();
    check("rst_rx_ready", 64'(rx_ready), 0);
    check("rst_tx_valid", 64'(tx_valid), 0);
    check("rst_tx_data", 64'(tx_data), 0);
    check("rst_result", 64'(result), 0);
    check("rst_result_valid", 64'(result_valid), 0);
    check("rst_err", 64'(err), 0);
    reset = 1'b0;
    step();
    check("rst_release_rx_ready", 64'(rx_ready), 1);

    txn("basic", 33, 3, 10, 4, 1'b0, 2, 1'b1, 7, 20, 5, 0, 0, v, r);
    check("basic_v_const", 64'(v), 18);
    check("basic_result_const", 64'(r), 20);

    txn("wrap", 33, 3, 7, 30, 1'b1, 2, 1'b0, 0, 0, 0, $urandom, 1, v, r);
    check("wrap_v_const", 64'(v), 5);
    check("wrap_result_const", 64'(r), 32);

    txn("full_b0", 128255609, 17, $urandom, $urandom, 1'b0, 5, 1'b1, 75431153, 12345, 67890, 0, 0, v, r);
    check("full_b0_const", 64'(r), 12345);

    rnd_rx   = 1'b1;
    stall_tx = 1'b1;
    txn("full_b1_bp", 128255609, 17, $urandom, $urandom, 1'b1, 5, 1'b1, 75431153, 12345, 67890, 0, 0, v, r);
    check("full_b1_const", 64'(r), 67890);
    rnd_rx   = 1'b0;
    stall_tx = 1'b0;

    txn("degen", 1, 3, 5, 6, 1'b0, 2, 1'b0, 0, 0, 0, $urandom, $urandom, v, r);
    check("degen_v_const", 64'(v), 0);
    check("degen_err_const", 64'(err), 1);
    txn("after_degen", 33, 3, 10, 4, 1'b0, 2, 1'b1, 7, 20, 5, 0, 0, v, r);
    check("after_degen_err", 64'(err), 0);

    send_key("mid_exp", 128255609, 17, 99, 100, 1'b0, 5);
    repeat (10) step();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    check("mid_exp_rx_ready", 64'(rx_ready), 1);
    check("mid_exp_tx_valid", 64'(tx_valid), 0);
    check("mid_exp_result", 64'(result), 0);
    txn("post_reset", 128255609, 17, $urandom, $urandom, 1'b1, 5, 1'b1, 75431153, 12345, 67890, 0, 0, v, r);
    check("post_reset_const", 64'(r), 67890);

    for (int t = 0; t < 10; t++) begin
      sel = $urandom_range(0, 5);
      rn  = $urandom;
      if (sel == 0) rn = $urandom_range(0, 1);
      else if (sel == 1) rn = $urandom_range(2, 300);
      re = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom;
      rk = ($urandom_range(0, 4) == 0) ? rn : $urandom;
      rnd_rx   = 1'($urandom_range(0, 1));
      stall_tx = 1'($urandom_range(0, 1));
      txn($sformatf("rand%0d", t), rn, re, $urandom, $urandom, 1'($urandom), rk, 1'b0, 0, 0, 0,
          $urandom, $urandom, v, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
